inst_mem_ctrl: RTL and testbench

Parametrised, loadable instruction memory for the RISC-V core. After reset it fills itself with NOPs, accepts a program over a valid/ready load port, then serves registered 32-bit instruction fetches to the IF stage. Fetches are stall-aware and report misaligned and out-of-range faults. It replaces hard-coded reset-time program contents with a run-time boot path.

---
 rtl/inst_mem_ctrl_if.sv | 39 +++
 rtl/inst_mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_inst_mem_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_ctrl_if.sv
// Load and fetch port bundle for the loadable instruction memory.
// The master side is the boot loader / IF stage, the slave side is inst_mem_ctrl.
interface inst_mem_ctrl_if #(
  parameter int DEPTH = 64
);
  localparam int IDX_W = $clog2(DEPTH);

  logic              boot_req;
  logic              busy;
  logic              ld_valid;
  logic              ld_ready;
  logic [31:0]       ld_addr;
  logic [31:0]       ld_data;
  logic [3:0]        ld_be;
  logic              ld_last;
  logic [IDX_W:0]    ld_count;
  logic              ld_err;
  logic              if_req;
  logic [31:0]       if_pc;
  logic              if_stall;
  logic              if_valid;
  logic [31:0]       if_inst;
  logic              if_fault;
  logic [1:0]        if_fault_code;

  modport master (
    output boot_req, ld_valid, ld_addr, ld_data, ld_be, ld_last,
    output if_req, if_pc, if_stall,
    input  busy, ld_ready, ld_count, ld_err,
    input  if_valid, if_inst, if_fault, if_fault_code
  );

  modport slave (
    input  boot_req, ld_valid, ld_addr, ld_data, ld_be, ld_last,
    input  if_req, if_pc, if_stall,
    output busy, ld_ready, ld_count, ld_err,
    output if_valid, if_inst, if_fault, if_fault_code
  );
endinterface

// File: rtl/inst_mem_ctrl.sv
// Loadable instruction memory: NOP-clears itself, accepts a program over the load
// port, then serves registered, stall-aware fetches with misalign/range faults.
module inst_mem_ctrl #(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic           clk,
  input  logic           rst,
  inst_mem_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] CLR_LAST = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] CLR_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0]   CNT_MAX  = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0]   CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {CLEAR = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

  state_t           state_r;
  logic [IDX_W-1:0] clr_cnt_r;
  logic [31:0]      mem [DEPTH];
  logic             busy_r;
  logic             ld_ready_r;
  logic [IDX_W:0]   ld_count_r;
  logic             ld_err_r;
  logic             if_valid_r;
  logic [31:0]      if_inst_r;
  logic             if_fault_r;
  logic [1:0]       if_code_r;

  logic             ld_acc_s;
  logic             ld_bad_s;
  logic             ld_we_s;
  logic             clr_we_s;
  logic [IDX_W-1:0] ld_idx_s;
  logic [IDX_W-1:0] if_idx_s;
  logic [1:0]       if_code_s;

  // Load acceptance, fetch fault classification and memory write enables
  always_comb begin
    ld_acc_s  = 1'b0;
    ld_bad_s  = 1'b0;
    ld_we_s   = 1'b0;
    clr_we_s  = 1'b0;
    if_code_s = 2'b00;
    ld_idx_s  = bus.ld_addr[IDX_W+1:2];
    if_idx_s  = bus.if_pc[IDX_W+1:2];
    ld_acc_s  = (state_r == LOAD) && bus.ld_valid;
    ld_bad_s  = (bus.ld_addr[1:0] != 2'b00) || (|bus.ld_addr[31:IDX_W+2]);
    ld_we_s   = !rst && ld_acc_s && !ld_bad_s;
    clr_we_s  = !rst && (state_r == CLEAR);
    // Misalignment outranks out-of-range
    if (bus.if_pc[1:0] != 2'b00) begin
      if_code_s = 2'b01;
    end else if (|bus.if_pc[31:IDX_W+2]) begin
      if_code_s = 2'b10;
    end else begin
      if_code_s = 2'b00;
    end
  end

  // Memory array: NOP fill during CLEAR, byte-enabled program writes during LOAD
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem[clr_cnt_r] <= NOP_INST;
    end else if (ld_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.ld_be[b]) begin
          mem[ld_idx_s][8*b +: 8] <= bus.ld_data[8*b +: 8];
        end
      end
    end
  end

  // Control FSM with registered status and fetch outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= CLEAR;
      clr_cnt_r  <= {IDX_W{1'b0}};
      busy_r     <= 1'b1;
      ld_ready_r <= 1'b0;
      ld_count_r <= {(IDX_W+1){1'b0}};
      ld_err_r   <= 1'b0;
      if_valid_r <= 1'b0;
      if_inst_r  <= NOP_INST;
      if_fault_r <= 1'b0;
      if_code_r  <= 2'b00;
    end else begin
      case (state_r)
        CLEAR: begin
          if_valid_r <= 1'b0;
          if (clr_cnt_r == CLR_LAST) begin
            state_r    <= LOAD;
            ld_ready_r <= 1'b1;
            clr_cnt_r  <= {IDX_W{1'b0}};
          end else begin
            clr_cnt_r  <= clr_cnt_r + CLR_ONE;
          end
        end
        LOAD: begin
          if_valid_r <= 1'b0;
          if (ld_acc_s) begin
            if (ld_bad_s) begin
              ld_err_r <= 1'b1;
            end else if (ld_count_r != CNT_MAX) begin
              ld_count_r <= ld_count_r + CNT_ONE;
            end
            // A dropped final beat still ends the load phase
            if (bus.ld_last) begin
              state_r    <= RUN;
              ld_ready_r <= 1'b0;
              busy_r     <= 1'b0;
            end
          end
        end
        RUN: begin
          if (bus.boot_req) begin
            state_r    <= CLEAR;
            clr_cnt_r  <= {IDX_W{1'b0}};
            busy_r     <= 1'b1;
            ld_count_r <= {(IDX_W+1){1'b0}};
            ld_err_r   <= 1'b0;
            if_valid_r <= 1'b0;
          end else if (!bus.if_stall) begin
            if_valid_r <= bus.if_req;
            if (bus.if_req) begin
              if_fault_r <= (if_code_s != 2'b00);
              if_code_r  <= if_code_s;
              if_inst_r  <= (if_code_s == 2'b00) ? mem[if_idx_s] : NOP_INST;
            end
          end
        end
        default: begin
          state_r    <= CLEAR;
          clr_cnt_r  <= {IDX_W{1'b0}};
          busy_r     <= 1'b1;
          ld_ready_r <= 1'b0;
          if_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy          = busy_r;
  assign bus.ld_ready      = ld_ready_r;
  assign bus.ld_count      = ld_count_r;
  assign bus.ld_err        = ld_err_r;
  assign bus.if_valid      = if_valid_r;
  assign bus.if_inst       = if_inst_r;
  assign bus.if_fault      = if_fault_r;
  assign bus.if_fault_code = if_code_r;
endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Scoreboard bench for inst_mem_ctrl: a word-array reference model predicts fetch
// responses into a queue that an independent monitor drains and compares.
module tb_inst_mem_ctrl;
  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_mem_ctrl_if #(.DEPTH(DEPTH)) bus();
  inst_mem_ctrl #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [DEPTH];
  int          ref_count;
  bit          ref_err;
  bit          ref_run;
  logic [34:0] exp_q[$];
  logic [34:0] exp_hold;
  bit          exp_valid;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected {inst, fault, code} for a fetch of byte address pc
  function automatic logic [34:0] ref_fetch(logic [31:0] pc);
    if (pc % 4 != 0) return {NOP, 1'b1, 2'b01};
    if (pc >= 4 * DEPTH) return {NOP, 1'b1, 2'b10};
    return {ref_mem[pc / 4], 1'b0, 2'b00};
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;
    ref_count = 0;
    ref_err   = 1'b0;
    ref_run   = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.boot_req = 1'b0; bus.ld_valid = 1'b0; bus.ld_addr = 32'h0; bus.ld_data = 32'h0;
    bus.ld_be = 4'h0; bus.ld_last = 1'b0; bus.if_req = 1'b0; bus.if_pc = 32'h0; bus.if_stall = 1'b0;
  endtask

  // Full clear: ld_ready must rise only after the DEPTH-th edge; stray requests ignored
  task automatic wait_clear(string tag);
    for (int i = 0; i < DEPTH; i++) begin
      bus.boot_req = 1'($urandom % 2);
      bus.if_req   = 1'($urandom % 2);
      bus.if_stall = 1'($urandom % 2);
      bus.if_pc    = $urandom_range(0, DEPTH - 1) * 4;
      bus.ld_valid = 1'($urandom % 2);
      bus.ld_addr  = $urandom_range(0, DEPTH - 1) * 4;
      bus.ld_data  = $urandom;
      bus.ld_be    = 4'hF;
      bus.ld_last  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_ld_ready"}, 64'(bus.ld_ready), 64'(i == DEPTH - 1));
      check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    end
    idle_inputs();
    check({tag, "_count"}, 64'(bus.ld_count), 64'(ref_count));
    check({tag, "_err"}, 64'(bus.ld_err), 64'(ref_err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    bus.if_req = 1'b1;
    rst = 1'b1;
    exp_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ref_clear();
    check("rst_busy", 64'(bus.busy), 64'd1);
    check("rst_ld_ready", 64'(bus.ld_ready), 64'd0);
    check("rst_ld_count", 64'(bus.ld_count), 64'd0);
    check("rst_ld_err", 64'(bus.ld_err), 64'd0);
    check("rst_if_out", {bus.if_valid, bus.if_inst, bus.if_fault, bus.if_fault_code},
          {1'b0, NOP, 1'b0, 2'b00});
    rst = 1'b0;
    wait_clear("clear");
  endtask

  task automatic load(logic [31:0] addr, logic [31:0] data, logic [3:0] be, bit last);
    int gap = $urandom_range(0, 2);
    bus.if_req = 1'($urandom % 2);
    bus.if_pc  = $urandom_range(0, DEPTH - 1) * 4;
    repeat (gap) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.ld_valid = 1'b1; bus.ld_addr = addr; bus.ld_data = data; bus.ld_be = be; bus.ld_last = last;
    check("ld_ready_offer", 64'(bus.ld_ready), 64'd1);
    @(posedge clk);
    if (addr % 4 != 0 || addr >= 4 * DEPTH) begin
      ref_err = 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[addr / 4][8*b +: 8] = data[8*b +: 8];
      if (ref_count < DEPTH) ref_count++;
    end
    if (last) ref_run = 1'b1;
    @(negedge clk);
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0; bus.if_req = 1'b0;
    check("ld_count", 64'(bus.ld_count), 64'(ref_count));
    check("ld_err", 64'(bus.ld_err), 64'(ref_err));
    check("busy_after_load", 64'(bus.busy), 64'(!ref_run));
    check("ld_ready_after_load", 64'(bus.ld_ready), 64'(!ref_run));
  endtask

  task automatic fetch_cycle(bit req, logic [31:0] pc, bit stall, bit boot);
    bus.if_req = req; bus.if_pc = pc; bus.if_stall = stall; bus.boot_req = boot;
    @(posedge clk);
    if (boot && ref_run) begin
      ref_clear();
    end else if (ref_run && !stall) begin
      exp_valid = req;
      if (req) exp_hold = ref_fetch(pc);
    end else if (!ref_run) begin
      exp_valid = 1'b0;
    end
    if (exp_valid) exp_q.push_back(exp_hold);
    @(negedge clk);
    bus.boot_req = 1'b0;
    if (boot) begin
      check("boot_if_valid", 64'(bus.if_valid), 64'd0);
      check("boot_busy", 64'(bus.busy), 64'd1);
    end
  endtask

  task automatic random_fetches(int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      case ($urandom % 4)
        0, 1:    pc = $urandom_range(0, DEPTH - 1) * 4;
        2:       pc = $urandom_range(0, 4 * DEPTH + 7);
        default: pc = $urandom;
      endcase
      fetch_cycle(($urandom % 4) != 0, pc, ($urandom % 4) == 0, 1'b0);
    end
  endtask

  // Monitor: every presented fetch response must match the oldest prediction
  always begin
    logic [34:0] e;
    @(posedge clk);
    #1;
    if (bus.if_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_fetch: if_valid=1 inst=%0h with no response expected", bus.if_inst);
      end else begin
        e = exp_q.pop_front();
        check("fetch", 64'({bus.if_inst, bus.if_fault, bus.if_fault_code}), 64'(e));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    do_reset();

    // Program with partial-byte write and two dropped beats
    load(32'h0,   32'h0094_0333, 4'hF, 1'b0);
    load(32'h4,   32'h8001_00B3, 4'hF, 1'b0);
    load(32'h10,  32'hAABB_CCDD, 4'b0101, 1'b0);
    load(32'h102, 32'h1234_5678, 4'hF, 1'b0);
    load(32'h100, 32'h1234_5678, 4'hF, 1'b0);
    load(32'h8,   32'h0020_9133, 4'hF, 1'b1);

    fetch_cycle(1'b1, 32'h0,   1'b0, 1'b0);
    fetch_cycle(1'b1, 32'h4,   1'b0, 1'b0);
    fetch_cycle(1'b1, 32'h8,   1'b0, 1'b0);
    fetch_cycle(1'b1, 32'hC,   1'b0, 1'b0);
    fetch_cycle(1'b1, 32'h10,  1'b0, 1'b0);
    fetch_cycle(1'b1, 32'h2,   1'b0, 1'b0);
    fetch_cycle(1'b1, 32'h100, 1'b0, 1'b0);
    fetch_cycle(1'b1, 32'h103, 1'b0, 1'b0);
    fetch_cycle(1'b0, 32'h0,   1'b0, 1'b0);

    // Stall holds the pc-4 response while the pc wanders
    fetch_cycle(1'b1, 32'h4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) fetch_cycle(1'b1, $urandom, 1'b1, 1'b0);
    random_fetches(300);

    // Boot request with a concurrent stalled fetch
    fetch_cycle(1'b1, 32'h8, 1'b1, 1'b1);
    wait_clear("boot");

    // Saturating reload ending in a dropped ld_last beat
    for (int i = 0; i < DEPTH + 6; i++)
      load($urandom_range(0, DEPTH - 1) * 4, $urandom, 4'($urandom), 1'b0);
    load(32'(4 * DEPTH - 4), $urandom, 4'hF, 1'b0);
    load(32'h200, $urandom, 4'hF, 1'b1);
    fetch_cycle(1'b1, 32'(4 * DEPTH - 4), 1'b0, 1'b0);
    fetch_cycle(1'b1, 32'(4 * DEPTH),     1'b0, 1'b0);
    random_fetches(200);

    // Reset in the middle of a load phase
    fetch_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    wait_clear("boot2");
    load(32'h0, 32'hDEAD_BEEF, 4'hF, 1'b0);
    load(32'h4, 32'hCAFE_F00D, 4'hF, 1'b0);
    do_reset();
    load(32'h0, 32'h0051_8193, 4'hF, 1'b1);
    fetch_cycle(1'b1, 32'h0, 1'b0, 1'b0);
    fetch_cycle(1'b1, 32'h4, 1'b0, 1'b0);
    random_fetches(50);

    fetch_cycle(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
